// File: rtl/wb_tlul_bridge.sv
// Wishbone classic slave to TL-UL host bridge: one outstanding transaction,
// with a timeout watchdog, sticky error flag and drain of late responses.
module wb_tlul_bridge #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        tl_a_valid,
   input  logic        tl_a_ready,
   output logic [2:0]  tl_a_opcode,
   output logic [1:0]  tl_a_size,
   output logic [31:0] tl_a_address,
   output logic [3:0]  tl_a_mask,
   output logic [31:0] tl_a_data,
   input  logic        tl_d_valid,
   output logic        tl_d_ready,
   input  logic [2:0]  tl_d_opcode,
   input  logic [31:0] tl_d_data,
   input  logic        tl_d_error,
   output logic        err_o,
   output logic        busy_o
);

   localparam int CW = $clog2(TIMEOUT + 2);

   typedef enum logic [2:0] {IDLE, REQ, RSP, ACK, DRAIN} state_t;

   state_t        state, state_next;
   logic [29:0]   adr_q;
   logic [31:0]   dat_q;
   logic [3:0]    sel_q;
   logic          we_q;
   logic [31:0]   rsp_q, rsp_next;
   logic [CW-1:0] cnt;
   logic          abandon, drain_pend, drain_next;
   logic          err_q, set_err;
   logic          timeout_hit, keep, d_bad;

   assign timeout_hit = ((state == REQ) || (state == RSP)) && (cnt == CW'(TIMEOUT));
   // A completion only reaches ACK if the master is still waiting for it.
   assign keep        = !abandon && wbs_cyc_i;
   assign d_bad       = tl_d_error || (tl_d_opcode != (we_q ? 3'd0 : 3'd1));

   always_comb begin
      state_next = state;
      rsp_next   = rsp_q;
      drain_next = drain_pend;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               state_next = (wbs_we_i && (wbs_sel_i == 4'h0)) ? ACK : REQ;
               rsp_next   = 32'h0;
               drain_next = 1'b0;
            end
         end
         REQ: begin
            if (timeout_hit) begin
               set_err    = 1'b1;
               rsp_next   = ERR_DATA;
               state_next = keep ? ACK : IDLE;
            end else if (tl_a_ready) begin
               state_next = RSP;
            end
         end
         RSP: begin
            if (tl_d_valid) begin
               if (d_bad) begin
                  set_err  = 1'b1;
                  rsp_next = ERR_DATA;
               end else begin
                  rsp_next = we_q ? 32'h0 : tl_d_data;
               end
               state_next = keep ? ACK : IDLE;
            end else if (timeout_hit) begin
               set_err    = 1'b1;
               rsp_next   = ERR_DATA;
               drain_next = 1'b1;
               state_next = keep ? ACK : DRAIN;
            end
         end
         ACK: begin
            state_next = drain_pend ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (tl_d_valid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         rsp_q      <= '0;
         cnt        <= '0;
         abandon    <= 1'b0;
         drain_pend <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_next;
         rsp_q      <= rsp_next;
         drain_pend <= drain_next;
         if (set_err) begin
            err_q <= 1'b1;
         end
         if ((state == IDLE) && wbs_cyc_i && wbs_stb_i) begin
            adr_q   <= wbs_adr_i[31:2];
            dat_q   <= wbs_dat_i;
            sel_q   <= wbs_sel_i;
            we_q    <= wbs_we_i;
            abandon <= 1'b0;
            cnt     <= '0;
         end else if ((state == REQ) || (state == RSP)) begin
            cnt <= cnt + 1'b1;
            if (!wbs_cyc_i) begin
               abandon <= 1'b1;
            end
         end
      end
   end

   assign tl_a_valid   = (state == REQ) && !timeout_hit;
   assign tl_a_opcode  = !we_q ? 3'd4 : ((sel_q == 4'hF) ? 3'd0 : 3'd1);
   assign tl_a_size    = 2'd2;
   assign tl_a_address = {adr_q, 2'b00};
   assign tl_a_mask    = we_q ? sel_q : 4'hF;
   assign tl_a_data    = dat_q;
   assign tl_d_ready   = (state == RSP) || (state == DRAIN);
   assign wbs_ack_o    = (state == ACK);
   assign wbs_dat_o    = (state == ACK) ? rsp_q : 32'h0;
   assign err_o        = err_q;
   assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_wb_tlul_bridge.sv
// Self-checking bench for wb_tlul_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_wb_tlul_bridge;

   localparam int          TMO      = 8;
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        tl_a_valid, tl_a_ready = 1'b0;
   logic [2:0]  tl_a_opcode;
   logic [1:0]  tl_a_size;
   logic [31:0] tl_a_address, tl_a_data;
   logic [3:0]  tl_a_mask;
   logic        tl_d_valid = 1'b0, tl_d_ready;
   logic [2:0]  tl_d_opcode = 3'd0;
   logic [31:0] tl_d_data = 32'h0;
   logic        tl_d_error = 1'b0;
   logic        err_o, busy_o;

   int   errors = 0;
   int   checks = 0;
   logic model_err = 1'b0;

   wb_tlul_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERR_WORD)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
      .tl_a_size(tl_a_size), .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask),
      .tl_a_data(tl_a_data),
      .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
      .tl_d_data(tl_d_data), .tl_d_error(tl_d_error),
      .err_o(err_o), .busy_o(busy_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
   endtask

   // One Wishbone transaction with a scripted TL responder; expectations are
   // derived from the request and the responder's delays alone.
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input int a_delay, input int d_delay,
                                input logic d_err, input logic bad_op, input logic [31:0] rdata);
      logic        skip, tmo, req_tmo, fail, a_bad;
      logic [2:0]  e_op, ok_op;
      logic [3:0]  e_mask;
      logic [31:0] e_data, ack_data;
      int          e_lat, e_aseen, n, a_seen, rsp_seen, ack_at;
      skip     = we && (sel == 4'h0);
      req_tmo  = !skip && (a_delay >= TMO);
      tmo      = !skip && (a_delay + d_delay + 2 > TMO + 1);
      fail     = tmo || (!skip && (d_err || bad_op));
      e_op     = !we ? 3'd4 : ((sel == 4'hF) ? 3'd0 : 3'd1);
      e_mask   = we ? sel : 4'hF;
      e_data   = fail ? ERR_WORD : ((we || skip) ? 32'h0 : rdata);
      e_lat    = skip ? 1 : (tmo ? TMO + 2 : 3 + a_delay + d_delay);
      e_aseen  = skip ? 0 : (req_tmo ? TMO : a_delay + 1);
      ok_op    = we ? 3'd0 : 3'd1;
      model_err = model_err | fail;

      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
      n = 0; a_seen = 0; rsp_seen = 0; ack_at = 0; a_bad = 1'b0; ack_data = 32'h0;
      while (ack_at == 0 && n < 30) begin
         nextCycle();
         n++;
         tl_d_valid = 1'b0;
         tl_a_ready = 1'b0;
         if (tl_a_valid) begin
            a_seen++;
            if (tl_a_opcode !== e_op || tl_a_mask !== e_mask || tl_a_size !== 2'd2 ||
                tl_a_address !== {adr[31:2], 2'b00} || (we && tl_a_data !== dat))
               a_bad = 1'b1;
            tl_a_ready = (a_seen == a_delay + 1);
         end else if (tl_d_ready) begin
            rsp_seen++;
            if (rsp_seen == d_delay + 1) begin
               tl_d_valid  = 1'b1;
               tl_d_data   = rdata;
               tl_d_error  = d_err;
               tl_d_opcode = bad_op ? (ok_op ^ 3'd1) : ok_op;
            end
         end
         if (wbs_ack_o) begin
            ack_at   = n;
            ack_data = wbs_dat_o;
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
         end
      end
      checkOutput("ack_latency", 32'(ack_at), 32'(e_lat));
      checkOutput("ack_data", ack_data, e_data);
      checkOutput("a_valid_cycles", 32'(a_seen), 32'(e_aseen));
      checkOutput("a_fields", 32'(a_bad), 32'h0);
      nextCycle();
      tl_d_valid = 1'b0;
      checkOutput("ack_single", 32'(wbs_ack_o), 32'h0);
      checkOutput("busy_after", 32'(busy_o), 32'(tmo && !req_tmo));
      checkOutput("err_sticky", 32'(err_o), 32'(model_err));
   endtask

   initial begin
      logic        any_bad;
      logic [31:0] r_adr, r_dat, r_rd;
      logic [3:0]  r_sel;
      int          pick;

      nextCycle();
      nextCycle();
      checkOutput("rst_ack", 32'(wbs_ack_o), 32'h0);
      checkOutput("rst_dat", wbs_dat_o, 32'h0);
      checkOutput("rst_a_valid", 32'(tl_a_valid), 32'h0);
      checkOutput("rst_d_ready", 32'(tl_d_ready), 32'h0);
      checkOutput("rst_err", 32'(err_o), 32'h0);
      checkOutput("rst_busy", 32'(busy_o), 32'h0);
      wb_rst_i = 1'b0;
      nextCycle();

      $display("[TB] directed read and partial write");
      applyStimulus(1'b0, 32'h1000_0006, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 32'h1234_5678);
      applyStimulus(1'b1, 32'h2000_0010, 32'hAABB_CCDD, 4'b0011, 5, 0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h3000_0000, 32'h5555_AAAA, 4'h0, 0, 0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h3000_0008, 32'h0102_0304, 4'hF, 1, 2, 1'b0, 1'b0, 32'h0);

      $display("[TB] randomized transactions");
      for (int i = 0; i < 24; i++) begin
         r_adr = $urandom;
         r_dat = $urandom;
         r_rd  = $urandom;
         pick  = int'($urandom_range(0, 3));
         r_sel = (pick == 0) ? 4'h0 : ((pick == 1) ? 4'hF : 4'($urandom));
         applyStimulus(1'($urandom), r_adr, r_dat, r_sel,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), r_rd);
      end

      $display("[TB] read with TL error");
      applyStimulus(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 1, 1'b1, 1'b0, 32'h7777_7777);
      applyStimulus(1'b0, 32'h4000_0004, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 32'h0BAD_F00D);

      $display("[TB] timeout in RSP then drain");
      applyStimulus(1'b0, 32'h5000_0000, 32'h0, 4'hF, 0, 100, 1'b0, 1'b0, 32'h0);
      checkOutput("drain_d_ready", 32'(tl_d_ready), 32'h1);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      any_bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         if (wbs_ack_o || tl_a_valid || !busy_o) any_bad = 1'b1;
      end
      checkOutput("drain_blocks_wb", 32'(any_bad), 32'h0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_error = 1'b0; tl_d_data = 32'h1111_2222;
      nextCycle();
      tl_d_valid = 1'b0;
      checkOutput("drain_done_busy", 32'(busy_o), 32'h0);
      checkOutput("drain_no_ack", 32'(wbs_ack_o), 32'h0);

      $display("[TB] timeout in REQ");
      applyStimulus(1'b1, 32'h5000_0040, 32'hCAFE_0001, 4'hF, 100, 0, 1'b0, 1'b0, 32'h0);

      $display("[TB] cyc dropped during RSP");
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h6000_0000; wbs_sel_i = 4'hF;
      any_bad = 1'b0;
      nextCycle();
      tl_a_ready = tl_a_valid;
      nextCycle();
      tl_a_ready = 1'b0;
      checkOutput("drop_rsp_d_ready", 32'(tl_d_ready), 32'h1);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      nextCycle();
      tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_error = 1'b0; tl_d_data = 32'h9999_0000;
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         tl_d_valid = 1'b0;
         if (wbs_ack_o) any_bad = 1'b1;
      end
      checkOutput("drop_no_ack", 32'(any_bad), 32'h0);
      checkOutput("drop_idle", 32'(busy_o), 32'h0);
      applyStimulus(1'b0, 32'h6000_0010, 32'h0, 4'hF, 1, 1, 1'b0, 1'b0, 32'h2468_ACE0);

      $display("[TB] reset pulse during REQ");
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h7000_0000;
      nextCycle();
      checkOutput("pre_rst_a_valid", 32'(tl_a_valid), 32'h1);
      wb_rst_i = 1'b1;
      nextCycle();
      wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      model_err = 1'b0;
      checkOutput("midrst_a_valid", 32'(tl_a_valid), 32'h0);
      checkOutput("midrst_busy", 32'(busy_o), 32'h0);
      checkOutput("midrst_err", 32'(err_o), 32'h0);
      checkOutput("midrst_dat", wbs_dat_o, 32'h0);
      tl_d_valid = 1'b1; tl_d_opcode = 3'd1;
      #1;
      checkOutput("late_d_ready", 32'(tl_d_ready), 32'h0);
      nextCycle();
      tl_d_valid = 1'b0;
      checkOutput("late_d_busy", 32'(busy_o), 32'h0);
      checkOutput("late_d_ack", 32'(wbs_ack_o), 32'h0);
      applyStimulus(1'b0, 32'h7000_0020, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 32'h1357_9BDF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_tlul_bridge.md
WB_TLUL_BRIDGE -- requirements
Module: wb_tlul_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles allowed in REQ or RSP before the bridge completes with an error.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on TL error or timeout.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; every flop is rising-edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-006 SHALL have ports wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  byte lanes, byte address, write data.
REQ-007 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  completion strobe and read data.
REQ-008 SHALL have ports tl_a_valid  out  1, tl_a_ready  in  1, tl_a_opcode  out  3, tl_a_size  out  2, tl_a_address  out  32, tl_a_mask  out  4, tl_a_data  out  32  TL-UL A channel toward the SoC crossbar.
REQ-009 SHALL have ports tl_d_valid  in  1, tl_d_ready  out  1, tl_d_opcode  in  3, tl_d_data  in  32, tl_d_error  in  1  TL-UL D channel.
REQ-010 SHALL have ports err_o  out  1 (sticky error flag) and busy_o  out  1 (state != IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, REQ, RSP, ACK, DRAIN; at most one transaction outstanding.
REQ-012 IDLE: on wbs_cyc_i & wbs_stb_i, SHALL latch adr/dat/sel/we and enter REQ on the next edge.
REQ-013 REQ: tl_a_valid SHALL be 1 with A fields stable until tl_a_valid & tl_a_ready, then enter RSP.
REQ-014 A fields: address {adr[31:2],2'b00}; size 2; reads opcode 4 (Get), mask 4'hF; writes with sel==4'hF opcode 0 (PutFullData); other writes opcode 1 (PutPartialData), mask = sel.
REQ-015 A write with sel==4'h0 SHALL skip the TL transaction and go directly to ACK.
REQ-016 RSP: tl_d_ready SHALL be 1; on tl_d_valid SHALL capture tl_d_data (reads) and tl_d_error, then enter ACK.
REQ-017 ACK: wbs_ack_o SHALL be 1 for exactly one cycle; the state SHALL then return to IDLE; minimum latency stb-to-ack is 3 cycles with a_ready and d_valid both immediate.
REQ-018 wbs_dat_o SHALL hold captured read data during ACK, ERR_DATA if tl_d_error or timeout, 0 at all other times.
REQ-019 tl_d_ready SHALL be 0 outside RSP and DRAIN; D beats arriving in IDLE/REQ/ACK are protocol violations and SHALL NOT change state.
REQ-020 tl_d_error or tl_d_opcode not matching the request (1 for Get, 0 for Put) SHALL set err_o and return ERR_DATA.
REQ-021 A timeout counter SHALL clear on entry to REQ and increment each cycle in REQ/RSP; reaching TIMEOUT SHALL set err_o and force ACK with ERR_DATA.
REQ-022 Timeout in REQ SHALL deassert tl_a_valid (no TL request issued); timeout in RSP SHALL go through ACK then DRAIN.
REQ-023 DRAIN: tl_d_ready SHALL be 1; the first tl_d_valid SHALL be discarded and the state SHALL return to IDLE; no new Wishbone request is accepted in DRAIN.
REQ-024 wbs_cyc_i dropping during REQ/RSP SHALL NOT abort the TL transaction; the bridge SHALL complete it and suppress wbs_ack_o (ACK state skipped).
REQ-025 err_o SHALL clear only on reset.

Reset
REQ-026 With wb_rst_i high at an edge: state IDLE, counter 0, wbs_ack_o 0, wbs_dat_o 0, tl_a_valid 0, tl_d_ready 0, err_o 0, busy_o 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it immediately; a late D beat after reset SHALL be ignored (tl_d_ready 0).

Verification
REQ-028 Read adr 32'h1000_0006, a_ready=1, d_valid next cycle with data 32'h1234_5678 -> A: opcode 4, address 32'h1000_0004, mask F; ack 3 cycles after stb with dat_o 32'h1234_5678.
REQ-029 Write sel 4'b0011 data 32'hAABB_CCDD, a_ready delayed 5 cycles -> a_valid held 6 cycles, opcode 1, mask 3, single ack after D beat.
REQ-030 Read with tl_d_error=1 -> ack with dat_o 32'hDEAD_BEEF, err_o stays 1 afterward.
REQ-031 TIMEOUT=8, d_valid never asserted -> ack 8 cycles after RSP entry with ERR_DATA; later D beat drained, then busy_o 0.
REQ-032 cyc dropped in RSP -> TL completes, no ack; next request served normally.
REQ-033 wb_rst_i pulse during REQ -> all outputs at reset values next cycle.
